// File: rtl/cart_mem_arb.sv
// cart_mem_arb
//   Shares one request/acknowledge cartridge memory port between the ROM
//   download path (buffered writes) and CPU cartridge reads. Cart-targeted
//   download bytes go into a small FIFO, which back-pressures the source via
//   IOCTL_WAIT. A three-state FSM drains the FIFO onto the memory port with
//   fixed priority over CPU reads. The block also tracks the loaded image
//   size and flags when the image is complete.
//
// Ports
//   CLK_SYS, RESB                 clock, async active-low reset
//   ROMINIT_*                     download stream (ACTIVE, SEL_CART, ADDR, DATA, VALID)
//   IOCTL_WAIT                    registered back-pressure to the download source
//   CPU_REQ/ADDR -> CPU_DOUT/ACK  CPU read (level request, one-cycle ack)
//   MEM_REQ/WE/ADDR/DIN           memory request, held until MEM_ACK
//   MEM_DOUT/MEM_ACK              memory response
//   CART_SIZE                     highest written cart address + 1 (AW+1 bits)
//   CART_READY                    download ended and all buffered writes drained
//   OVF                           sticky: a cart byte was dropped on a full FIFO
module cart_mem_arb #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 17
) (
    input  logic          CLK_SYS,
    input  logic          RESB,
    input  logic          ROMINIT_ACTIVE,
    input  logic          ROMINIT_SEL_CART,
    input  logic [AW-1:0] ROMINIT_ADDR,
    input  logic [7:0]    ROMINIT_DATA,
    input  logic          ROMINIT_VALID,
    output logic          IOCTL_WAIT,
    input  logic          CPU_REQ,
    input  logic [AW-1:0] CPU_ADDR,
    output logic [7:0]    CPU_DOUT,
    output logic          CPU_ACK,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [7:0]    MEM_DIN,
    input  logic [7:0]    MEM_DOUT,
    input  logic          MEM_ACK,
    output logic [AW:0]   CART_SIZE,
    output logic          CART_READY,
    output logic          OVF
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;

    logic cart_act, cart_act_q, dl_start, dl_seen;
    logic valid_cart, push, pop, full, empty;
    logic [AW:0] byte_end, size_base;

    assign cart_act   = ROMINIT_ACTIVE & ROMINIT_SEL_CART;
    assign dl_start   = cart_act & ~cart_act_q;
    assign valid_cart = ROMINIT_VALID & cart_act;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = valid_cart & ~full;
    assign pop        = (state == WRITE) & MEM_ACK;
    assign count_nxt  = count + CW'(push) - CW'(pop);

    // One extra bit so the top address (all ones) yields a size with no wrap.
    assign byte_end  = {1'b0, ROMINIT_ADDR} + {{AW{1'b0}}, 1'b1};
    // A byte arriving in the same cycle a download starts compares against 0.
    assign size_base = dl_start ? '0 : CART_SIZE;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge CLK_SYS) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ROMINIT_ADDR;
            fifo_data[wr_ptr] <= ROMINIT_DATA;
        end
    end

    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            IOCTL_WAIT <= 1'b0;
            OVF        <= 1'b0;
            CART_SIZE  <= '0;
            CART_READY <= 1'b0;
            cart_act_q <= 1'b0;
            dl_seen    <= 1'b0;
        end else begin
            cart_act_q <= cart_act;
            count      <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Threshold at DEPTH-1 leaves room for one byte already in flight.
            IOCTL_WAIT <= (count_nxt >= CW'(FIFO_DEPTH - 1));

            if (dl_start) begin
                OVF        <= valid_cart & full;
                CART_READY <= 1'b0;
                dl_seen    <= 1'b1;
            end else begin
                if (valid_cart & full) OVF <= 1'b1;
                if (dl_seen && !ROMINIT_ACTIVE && empty && state == IDLE)
                    CART_READY <= 1'b1;
            end

            if (push && byte_end > size_base) CART_SIZE <= byte_end;
            else if (dl_start)                CART_SIZE <= '0;
        end
    end

    // Memory port sequencer. Every access returns through IDLE, so there is
    // always at least one idle cycle between accesses.
    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            state    <= IDLE;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DIN  <= '0;
            CPU_DOUT <= '0;
            CPU_ACK  <= 1'b0;
        end else begin
            CPU_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= WRITE;
                        MEM_REQ  <= 1'b1;
                        MEM_WE   <= 1'b1;
                        MEM_ADDR <= fifo_addr[rd_ptr];
                        MEM_DIN  <= fifo_data[rd_ptr];
                    end else if (CPU_REQ && !CPU_ACK) begin
                        // ~CPU_ACK stops a re-issue while the CPU is still
                        // dropping its request after the previous ack.
                        state    <= READ;
                        MEM_REQ  <= 1'b1;
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= CPU_ADDR;
                    end
                end
                WRITE: begin
                    if (MEM_ACK) begin
                        state   <= IDLE;
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                    end
                end
                READ: begin
                    if (MEM_ACK) begin
                        state    <= IDLE;
                        MEM_REQ  <= 1'b0;
                        CPU_DOUT <= MEM_DOUT;
                        CPU_ACK  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    MEM_REQ <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cart_mem_arb.sv
// Bench for cart_mem_arb: directed scenarios plus a randomized download/read
// mix, checked against a queue of expected writes, a shadow memory and a
// running max of the image size.
module tb_cart_mem_arb;
    localparam int DEPTH = 4;
    localparam int AW    = 17;

    logic          CLK_SYS = 1'b0;
    logic          RESB = 1'b0;
    logic          ROMINIT_ACTIVE = 1'b0, ROMINIT_SEL_CART = 1'b0, ROMINIT_VALID = 1'b0;
    logic [AW-1:0] ROMINIT_ADDR = '0;
    logic [7:0]    ROMINIT_DATA = '0;
    logic          IOCTL_WAIT;
    logic          CPU_REQ = 1'b0;
    logic [AW-1:0] CPU_ADDR = '0;
    logic [7:0]    CPU_DOUT;
    logic          CPU_ACK;
    logic          MEM_REQ, MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [7:0]    MEM_DIN;
    logic [7:0]    MEM_DOUT = '0;
    logic          MEM_ACK = 1'b0;
    logic [AW:0]   CART_SIZE;
    logic          CART_READY, OVF;

    int n_vec = 0, n_err = 0;

    cart_mem_arb #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .CLK_SYS(CLK_SYS), .RESB(RESB),
        .ROMINIT_ACTIVE(ROMINIT_ACTIVE), .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
        .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
        .ROMINIT_VALID(ROMINIT_VALID), .IOCTL_WAIT(IOCTL_WAIT),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT), .MEM_ACK(MEM_ACK),
        .CART_SIZE(CART_SIZE), .CART_READY(CART_READY), .OVF(OVF)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dflt(input int a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // ---------------- memory responder ----------------
    int            ack_dly = 1;
    bit            rand_dly = 1'b0;
    int            rcnt = 0, cur_dly = 1;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_din;
    logic          st_we;
    logic [AW+7:0] wr_log[$];
    bit            op_log[$];
    bit [7:0]      mem[int];

    // MEM_ACK rises cur_dly cycles after the cycle MEM_REQ first rises.
    always @(negedge CLK_SYS) begin
        if (!RESB || !MEM_REQ) begin
            MEM_ACK = 1'b0;
            rcnt = 0;
        end else begin
            if (rcnt == 0) begin
                st_addr = MEM_ADDR; st_din = MEM_DIN; st_we = MEM_WE;
                cur_dly = rand_dly ? int'($urandom_range(1, 4)) : ack_dly;
            end
            rcnt++;
            MEM_ACK = 1'b0;
            if (rcnt == cur_dly + 1) begin
                chk("mem_stable", {st_we, st_addr, st_din}, {MEM_WE, MEM_ADDR, MEM_DIN});
                MEM_ACK = 1'b1;
                if (MEM_WE) begin
                    mem[int'(MEM_ADDR)] = MEM_DIN;
                    wr_log.push_back({MEM_ADDR, MEM_DIN});
                end else begin
                    MEM_DOUT = mem.exists(int'(MEM_ADDR)) ? mem[int'(MEM_ADDR)] : dflt(int'(MEM_ADDR));
                end
                op_log.push_back(MEM_WE);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [AW+7:0] exp_wr[$];
    bit [7:0]      shadow[int];
    logic [AW:0]   exp_size = '0;
    bit            cart_on = 1'b0;

    task automatic model_push(input logic [AW-1:0] a, input logic [7:0] d);
        logic [AW:0] e;
        e = {1'b0, a} + 1;
        if (e > exp_size) exp_size = e;
        exp_wr.push_back({a, d});
        shadow[int'(a)] = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_SYS);
    endtask

    // Starts and ends at a negedge; drives one VALID cycle.
    task automatic dl_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit sel, input bit honour);
        int t = 0;
        while (honour && IOCTL_WAIT && t < 200) begin @(negedge CLK_SYS); t++; end
        if (t >= 200) chk("wait_timeout", 1, 0);
        ROMINIT_ACTIVE = 1'b1; ROMINIT_SEL_CART = sel;
        ROMINIT_ADDR = a; ROMINIT_DATA = d; ROMINIT_VALID = 1'b1;
        if (sel && !cart_on) exp_size = '0;
        cart_on = sel;
        if (sel) model_push(a, d);
        @(negedge CLK_SYS);
        ROMINIT_VALID = 1'b0;
    endtask

    task automatic end_dl();
        ROMINIT_ACTIVE = 1'b0;
        cart_on = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] exp, input string tag, input bit chk_lat);
        int t = 0;
        CPU_REQ = 1'b1; CPU_ADDR = a;
        @(negedge CLK_SYS);
        if (chk_lat) chk({tag, "_lat"}, {MEM_REQ, MEM_WE}, 2'b10);
        while (!CPU_ACK && t < 300) begin @(negedge CLK_SYS); t++; end
        if (!CPU_ACK) chk({tag, "_timeout"}, 0, 1);
        else          chk(tag, CPU_DOUT, exp);
        CPU_REQ = 1'b0;
        @(negedge CLK_SYS);
        chk({tag, "_pulse"}, CPU_ACK, 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((wr_log.size() != exp_wr.size() || MEM_REQ) && t < 500) begin
            @(negedge CLK_SYS); t++;
        end
        chk("drain_count", wr_log.size(), exp_wr.size());
        tick(3);
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk(tag, wr_log[i], exp_wr[i]);
        wr_log.delete();
        exp_wr.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [AW-1:0] a;
        logic [7:0]    e;
        int            r;
        bit            saw;

        // ---- reset ----
        tick(3);
        chk("rst_ctl", {IOCTL_WAIT, CPU_ACK, MEM_REQ, MEM_WE, CART_READY, OVF}, 0);
        chk("rst_data", {MEM_ADDR, MEM_DIN}, 0);
        chk("rst_size", {CART_SIZE, CPU_DOUT}, 0);
        RESB = 1'b1;
        tick(2);
        chk("rel_outs", {IOCTL_WAIT, CPU_ACK, MEM_REQ, CART_READY, OVF, CART_SIZE}, 0);

        // ---- single byte ----
        ack_dly = 1;
        dl_byte(17'h00010, 8'hA5, 1'b1, 1'b1);
        chk("lat_e0", MEM_REQ, 0);
        tick(1);
        chk("lat_e1", {MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN}, {2'b11, 17'h00010, 8'hA5});
        drain();
        chk("single_notready", CART_READY, 0);
        chk("single_size", CART_SIZE, 18'h00011);
        end_dl();
        tick(3);
        chk("single_ready", CART_READY, 1);
        cmp_logs("single_wr");

        // ---- back-pressure, source honours WAIT ----
        ack_dly = 5;
        for (int i = 0; i < 8; i++) dl_byte(AW'(17'h200 + i), 8'(8'h11 * i + 1), 1'b1, 1'b1);
        drain();
        chk("bp_honour_ovf", OVF, 0);
        cmp_logs("bp_honour_wr");

        // ---- back-pressure, source ignores WAIT ----
        for (int i = 0; i < 8; i++) begin
            if (i == 2) chk("bp_wait_after2", IOCTL_WAIT, 0);
            if (i == 3) chk("bp_wait_after3", IOCTL_WAIT, 1);
            ROMINIT_ADDR = AW'(17'h300 + i); ROMINIT_DATA = 8'(8'hC0 + i); ROMINIT_VALID = 1'b1;
            if (i < DEPTH) model_push(ROMINIT_ADDR, ROMINIT_DATA);
            @(negedge CLK_SYS);
        end
        ROMINIT_VALID = 1'b0;
        drain();
        chk("bp_drop_ovf", OVF, 1);
        cmp_logs("bp_drop_wr");

        // ---- arbitration: reads wait for queued writes ----
        ack_dly = 3;
        mem[32'h100] = 8'h3C;
        shadow[32'h100] = 8'h3C;
        op_log.delete();
        for (int i = 0; i < 3; i++) dl_byte(AW'(17'h40 + i), 8'(8'h70 + i), 1'b1, 1'b0);
        cpu_read(17'h00100, 8'h3C, "arb_rd", 1'b0);
        chk("arb_nops", op_log.size(), 4);
        if (op_log.size() == 4)
            chk("arb_order", {op_log[0], op_log[1], op_log[2], op_log[3]}, 4'b1110);
        drain();
        cmp_logs("arb_wr");
        chk("ovf_sticky", OVF, 1);
        cpu_read(17'h00100, 8'h3C, "idle_rd", 1'b1);

        // ---- size at top address, restart clears ----
        ack_dly = 1;
        end_dl();
        tick(2);
        dl_byte(17'h1FFFF, 8'h11, 1'b1, 1'b1);
        dl_byte(17'h00000, 8'h22, 1'b1, 1'b1);
        drain();
        chk("wrap_size", CART_SIZE, 18'h20000);
        chk("restart_ovf", OVF, 0);
        end_dl();
        tick(3);
        chk("wrap_ready", CART_READY, 1);
        cmp_logs("wrap_wr");
        ROMINIT_ACTIVE = 1'b1; ROMINIT_SEL_CART = 1'b1; cart_on = 1'b1; exp_size = '0;
        tick(1);
        chk("restart_clr", {CART_SIZE, CART_READY}, 0);

        // ---- randomized mix ----
        rand_dly = 1'b1;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 9) == 0) ? AW'(17'h1FFC0 + $urandom_range(0, 63))
                                            : AW'($urandom_range(0, 63));
            if (r < 50)      dl_byte(a, 8'($urandom), 1'b1, 1'b1);
            else if (r < 62) dl_byte(a, 8'($urandom), 1'b0, 1'b1);
            else if (r < 75) tick(int'($urandom_range(1, 4)));
            else begin
                e = shadow.exists(int'(a)) ? shadow[int'(a)] : dflt(int'(a));
                cpu_read(a, e, "rnd_rd", 1'b0);
            end
        end
        end_dl();
        drain();
        chk("rnd_size", CART_SIZE, exp_size);
        chk("rnd_ready", CART_READY, 1);
        chk("rnd_ovf", OVF, 0);
        cmp_logs("rnd_wr");

        // ---- reset in the middle of a write ----
        rand_dly = 1'b0;
        ack_dly = 8;
        for (int i = 0; i < 3; i++) dl_byte(AW'(17'h500 + i), 8'(8'h90 + i), 1'b1, 1'b0);
        r = 0;
        while (!MEM_REQ && r < 20) begin @(negedge CLK_SYS); r++; end
        chk("mid_req_seen", MEM_REQ, 1);
        @(posedge CLK_SYS);
        #2;
        RESB = 1'b0;
        #1;
        chk("mid_req_drop", MEM_REQ, 0);
        chk("mid_outs", {IOCTL_WAIT, MEM_WE, CART_SIZE, CART_READY, OVF}, 0);
        @(negedge CLK_SYS);
        end_dl();
        RESB = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK_SYS);
            saw |= MEM_REQ;
        end
        chk("mid_idle", saw, 0);
        chk("mid_nowr", wr_log.size(), 0);
        chk("mid_wait", IOCTL_WAIT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
